// File: rtl/muldiv_unit_if.sv
// ID/EX-side bundle for the HI/LO multiply/divide unit.
// The pipeline drives the instruction and operands; the unit returns the MF result and its busy/stall status.
interface muldiv_unit_if;
   logic [31:0] idex_IR;
   logic [31:0] DataA;
   logic [31:0] DataB;
   logic [31:0] hilo_out;
   logic        busy;
   logic        stall;

   modport master (
      output idex_IR, DataA, DataB,
      input  hilo_out, busy, stall
   );

   modport slave (
      input  idex_IR, DataA, DataB,
      output hilo_out, busy, stall
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// It does 32 shift-add or restoring-divide steps on operand magnitudes, then applies the sign fix-up.
module muldiv_unit (
   input logic           clk,
   input logic           rst_n,
   muldiv_unit_if.slave  bus
);
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic [64:0] acc;
   logic [31:0] hi, lo, mag_a, mag_b;
   logic        op_div, neg_main, neg_rem, div_zero;
   logic        start_op, step, do_fix, move_en;

   logic [5:0]  funct;
   logic        is_r, is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, is_hilo;
   logic        unused_ir;

   assign funct     = bus.idex_IR[5:0];
   assign is_r      = (bus.idex_IR[31:26] == 6'b000000);
   assign unused_ir = ^bus.idex_IR[25:6];
   assign is_mul    = is_r && (funct == F_MULT || funct == F_MULTU);
   assign is_div    = is_r && (funct == F_DIV  || funct == F_DIVU);
   assign is_mfhi   = is_r && (funct == F_MFHI);
   assign is_mflo   = is_r && (funct == F_MFLO);
   assign is_mthi   = is_r && (funct == F_MTHI);
   assign is_mtlo   = is_r && (funct == F_MTLO);
   assign is_hilo   = is_mul || is_div || is_mfhi || is_mflo || is_mthi || is_mtlo;

   assign bus.stall = bus.busy && is_hilo;
   assign bus.busy  = (state != IDLE);

   // Signed variants have an even funct; unsigned ones never see a sign bit.
   logic        sign_a, sign_b;
   logic [31:0] abs_a, abs_b;
   assign sign_a = !funct[0] && bus.DataA[31];
   assign sign_b = !funct[0] && bus.DataB[31];
   assign abs_a  = sign_a ? -bus.DataA : bus.DataA;
   assign abs_b  = sign_b ? -bus.DataB : bus.DataB;

   // acc holds {carry/remainder, multiplier/quotient} so both algorithms share one shifter.
   logic [32:0] mul_sum, div_shift, div_trial;
   logic [63:0] product;
   logic [31:0] quot_fix, rem_fix;
   assign mul_sum   = acc[64:32] + {1'b0, mag_a};
   assign div_shift = {acc[63:32], acc[31]};
   assign div_trial = div_shift - {1'b0, mag_b};
   assign product   = neg_main ? -acc[63:0] : acc[63:0];
   assign quot_fix  = div_zero ? 32'hFFFF_FFFF : (neg_main ? -acc[31:0] : acc[31:0]);
   assign rem_fix   = neg_rem ? -acc[63:32] : acc[63:32];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_op   = 1'b0;
      step       = 1'b0;
      do_fix     = 1'b0;
      move_en    = 1'b0;
      case (state)
         IDLE: begin
            move_en = !bus.stall;
            if (!bus.stall && (is_mul || is_div)) begin
               start_op   = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == 5'd31) state_next = FIX;
         end
         FIX: begin
            do_fix     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi           <= '0;
         lo           <= '0;
         bus.hilo_out <= '0;
         count        <= '0;
         acc          <= '0;
         mag_a        <= '0;
         mag_b        <= '0;
         op_div       <= 1'b0;
         neg_main     <= 1'b0;
         neg_rem      <= 1'b0;
         div_zero     <= 1'b0;
      end else begin
         if (start_op) begin
            op_div   <= is_div;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= is_div && sign_a;
            div_zero <= is_div && (bus.DataB == 32'd0);
            acc      <= is_div ? {33'd0, abs_a} : {33'd0, abs_b};
            count    <= '0;
         end
         if (step) begin
            count <= count + 5'd1;
            if (op_div)
               acc <= div_trial[32] ? {div_shift, acc[30:0], 1'b0}
                                    : {div_trial, acc[30:0], 1'b1};
            else
               acc <= acc[0] ? {1'b0, mul_sum, acc[31:1]} : {1'b0, acc[64:1]};
         end
         if (do_fix) begin
            if (op_div) begin
               lo <= quot_fix;
               hi <= rem_fix;
            end else begin
               lo <= product[31:0];
               hi <= product[63:32];
            end
         end
         if (move_en) begin
            if (is_mthi) hi <= bus.DataA;
            if (is_mtlo) lo <= bus.DataA;
            if (is_mfhi) bus.hilo_out <= hi;
            if (is_mflo) bus.hilo_out <= lo;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: a plain-arithmetic HI/LO model predicts every MFHI/MFLO result,
// and a negedge monitor pops and compares each time the unit accepts an MF instruction.
module tb_muldiv_unit;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if bus_if ();
   muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

   int checks_total = 0;
   int checks_passed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;
   logic        pending = 1'b0;
   int          stall_cycles;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   function automatic logic is_mf(input logic [31:0] ir);
      return (ir[31:26] == 6'd0) && (ir[5:0] == F_MFHI || ir[5:0] == F_MFLO);
   endfunction

   // HI/LO behaviour in program order, from plain 64-bit arithmetic.
   task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sq, sr;
      case (f)
         F_MULT:  begin p = longint'($signed(a)) * longint'($signed(b)); {model_hi, model_lo} = p; end
         F_MULTU: begin p = {32'd0, a} * {32'd0, b}; {model_hi, model_lo} = p; end
         F_DIV, F_DIVU: begin
            if (b == 32'd0) begin
               model_lo = 32'hFFFF_FFFF;
               model_hi = a;
            end else if (f == F_DIV) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               p = sq; model_lo = p[31:0];
               p = sr; model_hi = p[31:0];
            end else begin
               model_lo = a / b;
               model_hi = a % b;
            end
         end
         F_MTHI: model_hi = a;
         F_MTLO: model_lo = a;
         F_MFHI: exp_q.push_back(model_hi);
         F_MFLO: exp_q.push_back(model_lo);
         default: ;
      endcase
   endtask

   // Holds the instruction in ID/EX until the unit stops stalling it, then replaces it with a NOP.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output int stalls);
      logic s;
      logic accepted;
      model_apply(f, a, b);
      bus_if.idex_IR = {26'd0, f};
      bus_if.DataA   = a;
      bus_if.DataB   = b;
      stalls   = 0;
      accepted = 1'b0;
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge clk);
         s = bus_if.stall;
         @(posedge clk);
         #1;
         if (!s) accepted = 1'b1;
         else    stalls++;
      end
      if (!accepted) begin
         checks_total++;
         $display("[TB] FAIL issue_timeout: funct %b still stalled after 100 cycles", f);
      end
      bus_if.idex_IR = 32'd0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (pending) begin
         if (exp_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL hilo_out_unexpected: got %h, expected no MF result", bus_if.hilo_out);
         end else begin
            checkOutput("hilo_out", bus_if.hilo_out, exp_q.pop_front());
         end
      end
      pending = rst_n && is_mf(bus_if.idex_IR) && !bus_if.stall;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] ops [6];
      ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
      bus_if.idex_IR = 32'd0;
      bus_if.DataA   = 32'd0;
      bus_if.DataB   = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("reset_hilo_out", bus_if.hilo_out, 32'd0);
      checkOutput("reset_stall", {31'd0, bus_if.stall}, 32'd0);
      @(posedge clk); #1;

      // Dependent MFLO stalls through E33 and reads the product at E34.
      applyStimulus(F_MULT, 32'd7, 32'hFFFF_FFFD, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      checkOutput("mult_mflo_stall_cycles", 32'(stall_cycles), 32'd33);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);

      applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);

      applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'd2, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_DIVU, 32'd100, 32'd7, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);

      // Divide by zero keeps full latency: busy still high after E32, low after E33.
      applyStimulus(F_DIV, 32'h0000_1234, 32'd0, stall_cycles);
      repeat (32) @(posedge clk);
      #1 checkOutput("div0_busy_after_e32", {31'd0, bus_if.busy}, 32'd1);
      @(posedge clk);
      #1 checkOutput("div0_busy_after_e33", {31'd0, bus_if.busy}, 32'd0);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      checkOutput("idle_mflo_stall_cycles", 32'(stall_cycles), 32'd0);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);

      applyStimulus(F_MTHI, 32'hA5A5_A5A5, 32'd0, stall_cycles);
      applyStimulus(F_MTLO, 32'h5A5A_5A5A, 32'd0, stall_cycles);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      checkOutput("move_mfhi_stall_cycles", 32'(stall_cycles), 32'd0);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);

      // Unrelated instructions keep flowing while busy.
      applyStimulus(F_MULTU, 32'd5, 32'd6, stall_cycles);
      bus_if.idex_IR = {26'd0, F_ADD};
      @(negedge clk);
      checkOutput("add_while_busy_busy", {31'd0, bus_if.busy}, 32'd1);
      checkOutput("add_while_busy_stall", {31'd0, bus_if.stall}, 32'd0);
      @(posedge clk); #1;
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);

      // Reset sampled at E10 of a MULT aborts it and clears HI/LO.
      applyStimulus(F_MULT, 32'h0001_2345, 32'h0000_0777, stall_cycles);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_hi = '0;
      model_lo = '0;
      checkOutput("midreset_busy", {31'd0, bus_if.busy}, 32'd0);
      checkOutput("midreset_hilo_out", bus_if.hilo_out, 32'd0);
      applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      applyStimulus(F_MULT, 32'd3, 32'd4, stall_cycles);
      applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      checkOutput("postreset_mflo_stall_cycles", 32'(stall_cycles), 32'd33);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(ops[$urandom_range(0, 5)], pick_operand(), pick_operand(), stall_cycles);
         applyStimulus(F_MFHI, 32'd0, 32'd0, stall_cycles);
         applyStimulus(F_MFLO, 32'd0, 32'd0, stall_cycles);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle HI/LO multiply/divide unit for the pipelined MIPS datapath, sitting in the EX stage next to `cp0`. It accepts MULT/MULTU/DIV/DIVU and HI/LO moves from the ID/EX instruction register and computes results over 34 cycles. While it is busy, it drives a stall request back to the hazard logic. It is the producer side of the HI/LO interface: `cp0` consumes the HI/LO values.

## Interface
- No parameters. Width is fixed at 32.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `idex_IR` input 32: instruction in ID/EX. Decode uses op `[31:26]` and funct `[5:0]`.
- `DataA` input 32: rs operand. Multiplicand, dividend, or MTHI/MTLO source.
- `DataB` input 32: rt operand. Multiplier or divisor.
- `hilo_out` output 32: registered MFHI/MFLO result, consumed by writeback.
- `busy` output 1: registered. High while an operation is in flight.
- `stall` output 1: combinational request to freeze IF/ID/EX.

## Operation
- Decode requires op = 000000. Funct values:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.
  - Any other instruction is ignored.
- `stall` = `busy` AND (`idex_IR` decodes to any of the eight instructions above). Unrelated instructions flow while busy.
- FSM states: IDLE, RUN, FIX.
  - **IDLE**: the edge acts only when `stall` is low.
    - MULT/DIV variants: latch the operand magnitudes, the result signs and the op type; counter ← 0; go to RUN; `busy` ← 1.
    - MTHI: HI ← `DataA`. MTLO: LO ← `DataA`.
    - MFHI: `hilo_out` ← HI. MFLO: `hilo_out` ← LO.
  - **RUN**: 32 iterations, one per edge. Counter 0..31; go to FIX after counter = 31.
    - Multiply is shift-add: 64-bit accumulator, one multiplier bit per cycle.
    - Divide is restoring: one quotient bit per cycle, with a 33-bit partial remainder.
  - **FIX**: apply sign correction, write HI/LO, go to IDLE, `busy` ← 0.
- Signed rules:
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - MULTU and DIVU skip negation.
- Divide results: quotient → LO, remainder → HI. Multiply results: HI = product[63:32], LO = product[31:0].
- Divide by zero, with the same latency: LO ← 32'hFFFFFFFF, HI ← dividend (`DataA` as issued).
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- HI/LO change only in FIX, on MTHI/MTLO, or on reset.

## Timing
- Reset (`rst_n` low at an edge): HI, LO, `hilo_out` = 0; `busy` = 0; state IDLE; counter = 0. An in-flight operation is aborted with no HI/LO write.
- Issue edge E0: MULT/DIV is sampled. `busy` is high from after E0 through E33.
  - RUN occupies E1..E32.
  - FIX at E33 writes HI/LO.
  - `busy` is low after E33.
- A dependent MFHI/MFLO held in ID/EX has `stall` high after E0 through E33. It samples the new value at E34, and `hilo_out` is valid after E34.
- Back-to-back MULT/DIV stalls the same way and issues at E34.
- MFHI/MFLO with `busy` low have a latency of 1 edge. MTHI followed by MFHI on consecutive instructions returns the new value.
- `stall` never depends on `hilo_out`, so there is no combinational loop.

## Test plan
- **Signed multiply**: MULT `DataA`=7, `DataB`=0xFFFFFFFD, then MFHI, MFLO → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO stalls for 33 cycles and `hilo_out` = 0xFFFFFFEB after E34.
- **Unsigned multiply**: MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands → HI=0, LO=1.
- **Division**:
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero**: DIV 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234. `busy` falls after E33.
- **Moves and independent traffic**:
  - MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A, MFHI, MFLO → `hilo_out` shows 0xA5A5A5A5 then 0x5A5A5A5A, with no stall.
  - A non-HI/LO instruction (e.g. ADD) during `busy` gives `stall`=0.
- **Reset mid-operation**: `rst_n` low at E10 of a MULT → `busy`=0, HI=LO=`hilo_out`=0. A following MULT 3×4 gives LO=12 after the full 34 cycles.
